// File: rtl/pmem_responder_pkg.sv
// lc3b_types: shared word/line types and the responder FSM state encoding.
package lc3b_types;
  typedef logic [15:0] lc3b_word;
  typedef logic [127:0] lc3b_c_block;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} lc3b_pmem_state;
endpackage

// File: rtl/pmem_responder_array.sv
// pmem_array: DEPTH_LINES x 128-bit line store, synchronous write, asynchronous read, never cleared.
module pmem_array
  import lc3b_types::*;
#(
  parameter int DEPTH_LINES = 256,
  localparam int AW = $clog2(DEPTH_LINES)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  lc3b_c_block   wdata_i,
  input  logic [AW-1:0] raddr_i,
  output lc3b_c_block   rdata_o
);
  lc3b_c_block mem_q [DEPTH_LINES];
  assign rdata_o = mem_q[raddr_i];
  // line write, deliberately outside reset so contents survive it
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end
endmodule

// File: rtl/pmem_responder.sv
// pmem_responder: fixed-latency physical memory model; PMEM_PROTOCOL_CHECK_EN adds a sticky proto_err output.
module pmem_responder
  import lc3b_types::*;
#(
  parameter int LATENCY     = 10,
  parameter int DEPTH_LINES = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pmem_read,
  input  logic        pmem_write,
  input  lc3b_word    pmem_address,
  input  lc3b_c_block pmem_wdata,
  output logic        pmem_resp,
  output lc3b_c_block pmem_rdata,
  output logic        busy
`ifdef PMEM_PROTOCOL_CHECK_EN
  , output logic      proto_err
`endif
);
  localparam int AW = $clog2(DEPTH_LINES);
  lc3b_pmem_state state_q, state_d;
  logic [7:0]     cnt_q, cnt_d;
  logic [AW-1:0]  idx_q, idx_d;
  logic           wr_q, wr_d;
  lc3b_c_block    wdata_q, wdata_d;
  lc3b_c_block    rdata_q, rdata_d;
  lc3b_c_block    arr_rdata;
  logic           unused_addr;
  // offset and alias bits above the line index are intentionally dropped
  assign unused_addr = ^{pmem_address[15:AW+4], pmem_address[3:0]};
  pmem_array #(.DEPTH_LINES(DEPTH_LINES)) u_array (
    .clk     (clk),
    .we_i    (state_q == RESP && wr_q),
    .waddr_i (idx_q),
    .wdata_i (wdata_q),
    .raddr_i (idx_q),
    .rdata_o (arr_rdata)
  );
  assign pmem_resp  = state_q == RESP;
  assign busy       = state_q != IDLE;
  assign pmem_rdata = (state_q == RESP && !wr_q) ? arr_rdata : rdata_q;
  // state and captured request registers; reset drops any pending request
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end
  // accept in IDLE (write wins over read), count down in BUSY, one-cycle RESP
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wr_d    = wr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: if (pmem_read || pmem_write) begin
        idx_d   = pmem_address[AW+3:4];
        wr_d    = pmem_write;
        wdata_d = pmem_wdata;
        cnt_d   = 8'(LATENCY - 1);
        state_d = (LATENCY == 1) ? RESP : BUSY;
      end
      BUSY: begin
        cnt_d   = cnt_q - 8'd1;
        state_d = (cnt_q <= 8'd1) ? RESP : BUSY;
      end
      RESP: begin
        state_d = IDLE;
        rdata_d = wr_q ? rdata_q : arr_rdata;
      end
      default: state_d = IDLE;
    endcase
  end
`ifdef PMEM_PROTOCOL_CHECK_EN
  lc3b_word paddr_q;
  logic     prd_q, pwr_q, perr_q, viol;
  assign viol = (state_q == IDLE) ? (pmem_read && pmem_write)
              : (pmem_address != paddr_q || pmem_read != prd_q || pmem_write != pwr_q);
  assign proto_err = perr_q;
  // sticky violation flag; request shadow follows inputs while IDLE so it holds the accepted one
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perr_q  <= 1'b0;
      paddr_q <= '0;
      prd_q   <= 1'b0;
      pwr_q   <= 1'b0;
    end else begin
      perr_q <= perr_q | viol;
      if (state_q == IDLE) begin
        paddr_q <= pmem_address;
        prd_q   <= pmem_read;
        pwr_q   <= pmem_write;
      end
    end
  end
`endif
endmodule
